tdm_audio_receiver: RTL
=======================

TDM_AUDIO_RECEIVER -- requirements
Module: tdm_audio_receiver

Interface
REQ-001 Parameter IO_WIDTH, 24, sample width per channel.
REQ-002 Parameter NUM_CH, 8, channels per TDM frame.
REQ-003 Parameter SLOT_WIDTH, 32, bclk periods per channel slot; SLOT_WIDTH >= IO_WIDTH.
REQ-004 Parameter SYNC_STAGES, 2, synchronizer flops on each serial input.
REQ-005 Port clk  input  1  system clock; one clock domain; all state on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port tdm_bclk  input  1  external bit clock, asynchronous to clk, period >= 8 clk periods.
REQ-008 Port tdm_fsync  input  1  external frame sync, asynchronous to clk.
REQ-009 Port tdm_sdata  input  1  serial data, MSB first.
REQ-010 Port audio_inputs  output  [IO_WIDTH-1:0] x [0:NUM_CH-1]  last complete frame, channel-indexed; feeds the DSP IO read port directly.
REQ-011 Port frame_valid  output  1  one-clk pulse when audio_inputs has just been updated.
REQ-012 Port frame_error  output  1  one-clk pulse when a frame is discarded.
REQ-013 Port locked  output  1  high while in RECEIVE.

Function
REQ-014 tdm_bclk, tdm_fsync and tdm_sdata shall each pass through SYNC_STAGES flops, followed by one edge-detect flop on bclk.
REQ-015 A bclk rising edge ("tick") shall be a one-clk pulse, asserted when the synchronized bclk is 1 and its delayed copy is 0; all serial sampling occurs only on ticks, using the synchronized fsync and sdata from the same clk.
REQ-016 Frame start: a tick where fsync = 1 and fsync at the previous tick = 0.
REQ-017 State machine with two states: HUNT and RECEIVE.
REQ-018 HUNT: frame start -> RECEIVE with bit_cnt = 0; no data is captured on the frame-start tick (one-bit delay).
REQ-019 RECEIVE: every tick after the frame-start tick carries one data bit; bit_cnt increments 0..NUM_CH*SLOT_WIDTH-1.
REQ-020 Slot = bit_cnt / SLOT_WIDTH; bit within slot = bit_cnt % SLOT_WIDTH; positions 0..IO_WIDTH-1 shift into that channel's shadow register, MSB first; remaining slot bits are ignored.
REQ-021 On the tick capturing slot NUM_CH-1, position IO_WIDTH-1, all NUM_CH shadow registers shall copy into audio_inputs on the next clk edge, with frame_valid high for exactly that one clk.
REQ-022 audio_inputs shall change only on that commit edge; all channels update on the same clk, so no mixed-frame value is ever visible.
REQ-023 Frame start while bit_cnt < NUM_CH*SLOT_WIDTH-1 and the commit has not yet occurred: shadow data is discarded, frame_error pulses one clk, audio_inputs is held, and a new frame starts (bit_cnt = 0; state stays RECEIVE).
REQ-024 Frame start after the commit but before bit_cnt wraps (short trailing slots): a new frame starts with no error.
REQ-025 bit_cnt reaching NUM_CH*SLOT_WIDTH-1 with no frame start on the next tick: frame_error pulses, state -> HUNT, audio_inputs is held.
REQ-026 Frame start on exactly tick NUM_CH*SLOT_WIDTH after the previous frame start: normal back-to-back frame, no error.
REQ-027 If frame_valid and frame_error would coincide, frame_valid wins and frame_error is suppressed.
REQ-028 locked = 1 iff state == RECEIVE.

Reset
REQ-029 Asserting reset at any time, including mid-frame, shall immediately force: state HUNT, bit_cnt 0, all shadow registers 0, all audio_inputs 0, frame_valid 0, frame_error 0, locked 0, and all synchronizer and edge flops 0.
REQ-030 After reset deassertion, no tick shall be generated until bclk is seen low and then high through the synchronizers; the first frame is accepted only on a fresh frame start.

Verification
REQ-031 Clean frames: bclk = clk/8, channel n = 24'h100000+n, two consecutive frames -> frame_valid once per frame, audio_inputs[n] = 24'h100000+n, frame_error never high.
REQ-032 Latency: commit clk edge occurs exactly SYNC_STAGES+2 clks after the bclk rising edge carrying ch7 bit 0; bench checks the exact cycle.
REQ-033 Early fsync: fsync pulse after 100 data bits -> frame_error one clk, audio_inputs keep the previous frame, the next full frame commits correctly.
REQ-034 fsync stops after one good frame -> frame_error once at bit 255, locked drops, audio_inputs hold their values, no frame_valid.
REQ-035 Reset pulse asserted at bit 150 of a frame -> all outputs 0 asynchronously; the partial frame is never committed; the next full frame commits.
REQ-036 Full-scale values: ch0 = 24'hFFFFFF, ch7 = 24'h800000, slot padding bits = 1 -> exact values captured; padding does not leak into any channel.

Source files
------------

// File: rtl/tdm_audio_if.sv
// Serial TDM input pins plus the frame outputs presented to the DSP read port.
// master = serial source / frame consumer, slave = the receiver.
interface tdm_audio_if #(
    parameter int IO_WIDTH = 24,
    parameter int NUM_CH   = 8
);
    logic                tdm_bclk;
    logic                tdm_fsync;
    logic                tdm_sdata;
    logic [IO_WIDTH-1:0] audio_inputs [0:NUM_CH-1];
    logic                frame_valid;
    logic                frame_error;
    logic                locked;

    modport master (
        output tdm_bclk, tdm_fsync, tdm_sdata,
        input  audio_inputs, frame_valid, frame_error, locked
    );

    modport slave (
        input  tdm_bclk, tdm_fsync, tdm_sdata,
        output audio_inputs, frame_valid, frame_error, locked
    );
endinterface

// File: rtl/tdm_audio_receiver.sv
// TDM audio receiver: oversamples an asynchronous bclk/fsync/sdata stream in the
// clk domain and publishes each complete frame to audio_inputs in one clk.
//
//   state   | meaning
//   HUNT    | waiting for a fresh fsync rising edge; outputs held
//   RECEIVE | counting data bits of the current frame, shifting channel shadows
module tdm_audio_receiver #(
    parameter int IO_WIDTH    = 24,
    parameter int NUM_CH      = 8,
    parameter int SLOT_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    tdm_audio_if.slave bus
);
    localparam int FRAME_BITS = NUM_CH * SLOT_WIDTH;
    localparam int CW         = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST_CNT   = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] COMMIT_CNT = CW'((NUM_CH - 1) * SLOT_WIDTH + IO_WIDTH - 1);
    localparam logic [CW-1:0] SLOT_W     = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] IO_W       = CW'(IO_WIDTH);

    typedef enum logic {HUNT, RECEIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] bclk_sync, fsync_sync, sdata_sync, sync_vld;
    logic bclk_s, fsync_s, sdata_s;
    logic bclk_d, bclk_armed, tick_seen, fsync_prev;
    logic tick, frame_start;

    logic [CW-1:0]       bit_cnt;
    logic [CW-1:0]       slot_idx, slot_pos;
    logic [IO_WIDTH-1:0] shadow [0:NUM_CH-1];
    logic                commit_q;
    logic                restart, capture, err_now;

    assign bclk_s  = bclk_sync[SYNC_STAGES-1];
    assign fsync_s = fsync_sync[SYNC_STAGES-1];
    assign sdata_s = sdata_sync[SYNC_STAGES-1];

    // Ticks are gated until bclk has been seen low through a filled synchronizer,
    // so a bclk held high across reset release cannot fake a rising edge.
    assign tick        = bclk_s && !bclk_d && bclk_armed;
    assign frame_start = tick && fsync_s && !fsync_prev && tick_seen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync  <= '0;
            fsync_sync <= '0;
            sdata_sync <= '0;
            sync_vld   <= '0;
            bclk_d     <= 1'b0;
            bclk_armed <= 1'b0;
            tick_seen  <= 1'b0;
            fsync_prev <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bus.tdm_bclk};
            fsync_sync <= {fsync_sync[SYNC_STAGES-2:0], bus.tdm_fsync};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], bus.tdm_sdata};
            sync_vld   <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            bclk_d     <= bclk_s;
            if (sync_vld[SYNC_STAGES-1] && !bclk_s)
                bclk_armed <= 1'b1;
            if (tick) begin
                tick_seen  <= 1'b1;
                fsync_prev <= fsync_s;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= HUNT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        capture = 1'b0;
        err_now = 1'b0;
        case (state_q)
            HUNT: begin
                if (frame_start) begin
                    state_d = RECEIVE;
                    restart = 1'b1;
                end
            end
            RECEIVE: begin
                if (frame_start) begin
                    restart = 1'b1;
                    err_now = (bit_cnt <= COMMIT_CNT);
                end else if (tick) begin
                    if (bit_cnt == LAST_CNT) begin
                        err_now = 1'b1;
                        state_d = HUNT;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign slot_idx = bit_cnt / SLOT_W;
    assign slot_pos = bit_cnt % SLOT_W;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt         <= '0;
            commit_q        <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.frame_error <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c]           <= '0;
                bus.audio_inputs[c] <= '0;
            end
        end else begin
            commit_q        <= capture && (bit_cnt == COMMIT_CNT);
            bus.frame_valid <= commit_q;
            bus.frame_error <= err_now && !commit_q;
            // Shadows are only copied once the last sample bit has landed, so the
            // DSP never observes a frame mixing old and new channels.
            if (commit_q) begin
                for (int c = 0; c < NUM_CH; c++)
                    bus.audio_inputs[c] <= shadow[c];
            end
            if (restart) begin
                bit_cnt <= '0;
            end else if (capture) begin
                bit_cnt <= bit_cnt + CW'(1);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (slot_idx == CW'(c) && slot_pos < IO_W)
                        shadow[c] <= {shadow[c][IO_WIDTH-2:0], sdata_s};
                end
            end
        end
    end

    assign bus.locked = (state_q == RECEIVE);

endmodule
